// File: rtl/serial_word_deser_if.sv
// Serial bit stream in, framed parallel word out with valid/ready, plus status flags.
interface serial_word_deser_if #(
    parameter int WIDTH = 8
);
    logic             serial_in;
    logic             serial_valid;
    logic             start;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             overrun;
    logic             clear_err;

    modport master (
        output serial_in, serial_valid, start, data_ready, clear_err,
        input  data, data_valid, busy, overrun
    );

    modport slave (
        input  serial_in, serial_valid, start, data_ready, clear_err,
        output data, data_valid, busy, overrun
    );
endinterface

// File: rtl/serial_word_deser.sv
// LSB-first serial-to-parallel deserializer; word valid the cycle after its last bit.
// One-word holding slot; a completion into a full, undrained slot is dropped and flags overrun.
module serial_word_deser #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_word_deser_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    // Only the WIDTH-1 most recent bits are stored; the final bit joins them on completion.
    logic [WIDTH-2:0] sr, sr_nxt;
    logic [WIDTH-1:0] word;
    logic             complete;

    logic [WIDTH-1:0] data_q;
    logic             data_valid_q;
    logic             overrun_q;
    logic             load;
    logic             drop;

    assign word = {bus.serial_in, sr};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        complete  = 1'b0;
        if (bus.serial_valid) begin
            if (bus.start) begin
                // A start always begins a fresh word, abandoning any partial one.
                sr_nxt           = '0;
                sr_nxt[WIDTH-2]  = bus.serial_in;
                cnt_nxt          = CW'(1);
                state_nxt        = SHIFT;
            end else if (state == SHIFT) begin
                sr_nxt = word[WIDTH-1:1];
                if (cnt == CW'(WIDTH - 1)) begin
                    complete  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
        end
    end

    assign load = complete && (!data_valid_q || bus.data_ready);
    assign drop = complete && data_valid_q && !bus.data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (load) begin
                data_q       <= word;
                data_valid_q <= 1'b1;
            end else if (data_valid_q && bus.data_ready) begin
                data_valid_q <= 1'b0;
            end
            // Overrun event wins over a simultaneous clear.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.clear_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state == SHIFT);
endmodule

// File: tb/tb_serial_word_deser.sv
// Randomized and directed bench for serial_word_deser with a queue-based scoreboard.
module tb_serial_word_deser;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_word_deser_if #(.WIDTH(WIDTH)) bus();

    serial_word_deser #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the word in progress, expected slot contents, sticky flag.
    bit               bits[$];
    logic [WIDTH-1:0] sb[$];
    logic             exp_full = 1'b0;
    logic             exp_ovr  = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        bits.delete();
        sb.delete();
        exp_full = 1'b0;
        exp_ovr  = 1'b0;
    endfunction

    function automatic void model_edge(input bit b, input bit v, input bit s, input bit r, input bit c);
        bit done = 0;
        bit ovf  = 0;
        int acc  = 0;
        if (v) begin
            if (s) begin
                bits.delete();
                bits.push_back(b);
            end else if (bits.size() > 0) begin
                bits.push_back(b);
                if (bits.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) acc += int'(bits[i]) * (1 << i);
                    done = 1;
                    bits.delete();
                end
            end
        end
        if (done) begin
            if (!exp_full || r) begin
                sb.push_back(acc[WIDTH-1:0]);
                exp_full = 1'b1;
            end else begin
                ovf = 1;
            end
        end else if (exp_full && r) begin
            exp_full = 1'b0;
        end
        if (ovf) exp_ovr = 1'b1;
        else if (c) exp_ovr = 1'b0;
    endfunction

    task automatic step(input bit b, input bit v, input bit s, input bit r, input bit c);
        bus.serial_in    = b;
        bus.serial_valid = v;
        bus.start        = s;
        bus.data_ready   = r;
        bus.clear_err    = c;
        model_edge(b, v, s, r, c);
        @(posedge clk);
        #1;
        check("data_valid", 32'(bus.data_valid), 32'(exp_full));
        check("busy", 32'(bus.busy), 32'(bits.size() != 0));
        check("overrun", 32'(bus.overrun), 32'(exp_ovr));
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random, 3 ready only on the last bit
    task automatic send_word(input logic [WIDTH-1:0] w, input int gapmax, input int rmode);
        for (int i = 0; i < WIDTH; i++) begin
            bit r;
            int gaps = (gapmax > 0 && i > 0) ? $urandom_range(gapmax, 0) : 0;
            for (int g = 0; g < gaps; g++) begin
                r = (rmode == 1) || (rmode == 2 && $urandom_range(1, 0) == 1);
                step(1'b0, 1'b0, 1'b0, r, 1'b0);
            end
            case (rmode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                2:       r = $urandom_range(1, 0) == 1;
                default: r = (i == WIDTH - 1);
            endcase
            step(w[i], 1'b1, (i == 0), r, 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r, 1'b0);
    endtask

    task automatic do_reset();
        bus.serial_valid = 1'b0;
        bus.start        = 1'b0;
        bus.data_ready   = 1'b0;
        bus.clear_err    = 1'b0;
        rst = 1'b1;
        model_clear();
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every cycle the slot is full its contents must equal the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none at %0t", bus.data, $time);
            end else begin
                check("data", 32'(bus.data), 32'(sb[0]));
                if (bus.data_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.serial_in    = 1'b0;
        bus.serial_valid = 1'b0;
        bus.start        = 1'b0;
        bus.data_ready   = 1'b0;
        bus.clear_err    = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Back-to-back and gapped delivery of 0xBB.
        send_word(8'hBB, 0, 1);
        idle(3, 1'b1);
        send_word(8'hBB, 3, 1);
        idle(3, 1'b1);

        // Abandoned partial word followed by a full restart.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h5A, 0, 1);
        idle(3, 1'b1);

        // Overrun with a stalled consumer, then clear and drain.
        send_word(8'h01, 0, 0);
        send_word(8'h02, 0, 0);
        idle(3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Drain and load on the same edge.
        send_word(8'h01, 0, 0);
        send_word(8'h02, 0, 3);
        idle(3, 1'b1);

        // Reset mid-word with a full slot, then a clean word.
        send_word(8'h33, 0, 0);
        for (int i = 0; i < 4; i++) step(1'($urandom_range(1, 0)), 1'b1, (i == 0), 1'b0, 1'b0);
        do_reset();
        idle(2, 1'b1);
        send_word(8'hC6, 0, 1);
        idle(3, 1'b1);

        // Random words with random gaps and consumer behaviour.
        for (int n = 0; n < 40; n++) begin
            send_word(WIDTH'($urandom), $urandom_range(2, 0), 2);
            if ($urandom_range(3, 0) == 0) step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(1, 0)));
        end

        // Fully random bit-level stimulus including spurious starts and clears.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0),
                 ($urandom_range(11, 0) == 0), ($urandom_range(2, 0) != 0),
                 ($urandom_range(15, 0) == 0));
        end

        idle(4, 1'b1);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_word_deser.md
# serial_word_deser

Serial-to-parallel receiver for the LSB-first, one-bit-per-clock serial streams produced by the team's serial arithmetic units. It frames a WIDTH-bit word from a start-marked bit stream and presents it on a parallel port with a valid/ready handshake. A one-word output holding slot lets the next word shift in while the consumer drains the current one. Overrun is flagged sticky.

## Interface
- WIDTH, default 8, word length in bits; legal range 2..32
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high; clears all state
- serial_in  input  1  serial data bit, LSB first
- serial_valid  input  1  serial_in is sampled on this edge
- start  input  1  qualifies first bit (bit 0) of a word; ignored unless serial_valid=1
- data  output  WIDTH  assembled word in holding slot
- data_valid  output  1  holding slot is full
- data_ready  input  1  consumer accepts data this edge
- busy  output  1  a word is partially received
- overrun  output  1  sticky: a completed word was dropped
- clear_err  input  1  synchronous clear of overrun

## Operation
- State machine: IDLE, SHIFT.
- IDLE:
  - serial_valid=1 and start=1: load the bit into the shift register, set bit count to 1, go to SHIFT.
  - serial_valid=1 and start=0: bit discarded, stay in IDLE.
- SHIFT, serial_valid=1, start=0:
  - Shift right with the new bit entering at MSB: sr <= {serial_in, sr[WIDTH-1:1]}; count increments.
  - On the WIDTH-th bit, the word is complete and the FSM returns to IDLE. After WIDTH shifts, bit 0 of sr holds the first received bit.
- SHIFT, serial_valid=1, start=1: partial word is abandoned (no flag). The bit becomes bit 0 of a new word; count=1; stay in SHIFT.
- SHIFT, serial_valid=0: hold all state, including count. Gaps are allowed between bits.
- Completion with slot empty, or slot being drained the same edge (data_valid=1 and data_ready=1): word is written to data; data_valid=1.
- Completion with slot full and data_ready=0: the new word is dropped; overrun set to 1; data is unchanged.
- Handshake:
  - The transfer occurs on an edge where data_valid=1 and data_ready=1.
  - data_valid then clears, unless a completion loads the slot on the same edge.
  - data must be stable while data_valid=1 and data_ready=0.
- data_ready while data_valid=0 has no effect.
- clear_err=1 clears overrun. If an overrun event happens on the same edge, set wins and overrun stays 1.
- busy = (state == SHIFT).

## Timing
- Reset values:
  - state IDLE, count 0
  - data all zeros, data_valid 0, busy 0, overrun 0
- Reset asserted mid-word or with the slot full: everything is discarded immediately; nothing is delivered after release.
- Latency: data_valid rises on the same clock edge that samples the WIDTH-th bit, so it is visible in the following cycle.
- Throughput: back-to-back words at one bit per clock. The start of the next word may be on the cycle right after the last bit.
- With the consumer holding data_ready=1 continuously, no overrun occurs at full rate.
- All outputs are registered, except busy, which is decoded from the state register.

## Test plan
- Reset then stream, WIDTH=8:
  - Stimulus: start on first bit, bits 1,1,0,1,1,1,0,1 on consecutive cycles with data_ready=1.
  - Required: data=8'hBB with data_valid=1 for exactly one cycle; busy=1 for 7 cycles.
- Gapped stream:
  - Stimulus: same bits with serial_valid=0 inserted between them.
  - Required: data=8'hBB, delivered one cycle after the last valid bit.
- Restart:
  - Stimulus: 3 bits, then a new start followed by 8 bits encoding 8'h5A.
  - Required: only 8'h5A is delivered; overrun=0.
- Overrun:
  - Stimulus: two back-to-back words 8'h01 and 8'h02 with data_ready=0.
  - Required: data stays 8'h01, overrun=1. clear_err later returns overrun to 0. Then data_ready=1 drains 8'h01.
- Simultaneous drain and load:
  - Stimulus: data_ready=1 asserted on the edge the second word completes.
  - Required: data_valid stays 1, data switches from 8'h01 to 8'h02, overrun=0.
- Reset mid-word:
  - Stimulus: assert reset after 4 bits.
  - Required: busy=0 and data_valid=0 immediately. The next full word is received correctly.
